// File: rtl/ppa_pkg.sv
// ppa_pkg: shared types and limits for pending_priority_arbiter.
//   ppa_state_t : offer FSM state (IDLE, OFFER)
//   N_MAX       : largest supported number of request lines
package ppa_pkg;

  localparam int unsigned N_MAX = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } ppa_state_t;

endpackage

// File: rtl/prio_enc_n.sv
// prio_enc_n: combinational N-input find-highest encoder with a movable
// top-priority position.
//   in  [N] : candidate vector
//   ptr [W] : index of the highest-priority line (N-1 gives plain
//             highest-index-wins)
//   out [W] : index of the winning line (0 when none)
//   any     : at least one bit of in is set
module prio_enc_n #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] in,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] out,
  output logic         any
);

  import ppa_pkg::*;

  // Rotating by N-1-ptr puts line ptr at the top; position j of the rotated
  // vector is line (ptr+1+j) mod N. Scanning j upward and keeping the last
  // hit gives the highest rotated position, already un-rotated.
  always_comb begin
    int unsigned k;
    k   = 0;
    out = '0;
    any = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      k = 32'(ptr) + 32'd1 + j;
      if (k >= N) k = k - N;
      if (in[k[W-1:0]]) begin
        any = 1'b1;
        out = k[W-1:0];
      end
    end
  end

endmodule

// File: rtl/pending_priority_arbiter.sv
// pending_priority_arbiter: collects requests into a sticky pending register
// and offers the highest-priority unmasked pending index on valid/ready.
// Each accepted index is retired from pending.
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset
//   req  [N] : request levels; a high bit sets its pending bit
//   mask [N] : 1 excludes a line from selection (pending bit retained)
//   clr      : clear all pending bits and drop the current offer
//   ready    : consumer accepts the current offer
//   valid    : an offer is present on idx
//   idx  [W] : offered line index
//   pending [N] : pending register
// Build option: PPA_ROUND_ROBIN_EN selects rotating priority; without it
// priority is fixed, highest index wins.
module pending_priority_arbiter #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         clr,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] pending
);

  import ppa_pkg::*;

  ppa_state_t   state_q, state_d;
  logic [W-1:0] idx_d;
  logic         acc;
  logic [N-1:0] acc_onehot;
  logic [N-1:0] cand_vec;
  logic [W-1:0] cand_idx;
  logic         cand_any;
  logic [W-1:0] ptr_eff;

  assign acc        = valid & ready;
  assign acc_onehot = acc ? (N'(1) << idx) : '0;
  // The line being retired this cycle must not be re-offered back-to-back.
  assign cand_vec   = pending & ~acc_onehot & ~mask;

`ifdef PPA_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  // The candidate chosen in an accept cycle already uses the updated
  // pointer, so the just-accepted line ranks lowest immediately.
  always_comb begin
    ptr_d = ptr_q;
    if (acc) ptr_d = (idx == '0) ? W'(N - 1) : idx - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= W'(N - 1);
    else          ptr_q <= ptr_d;
  end

  assign ptr_eff = ptr_d;
`else
  assign ptr_eff = W'(N - 1);
`endif

  prio_enc_n #(.N(N)) u_enc (
    .in  (cand_vec),
    .ptr (ptr_eff),
    .out (cand_idx),
    .any (cand_any)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx     <= '0;
      pending <= '0;
    end else begin
      state_q <= state_d;
      idx     <= idx_d;
      pending <= clr ? '0 : ((pending & ~acc_onehot) | req);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cand_any) begin
            idx_d   = cand_idx;
            state_d = OFFER;
          end
        end
        OFFER: begin
          if (ready) begin
            if (cand_any) idx_d = cand_idx;
            else          state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    valid = (state_q == OFFER);
  end

endmodule

// File: tb/tb_pending_priority_arbiter.sv
// tb_pending_priority_arbiter: directed bench for pending_priority_arbiter
// with N = 8. Expected accepted indices are queued as stimulus is applied
// and checked whenever the DUT completes a valid/ready handshake.
// Round-robin steps are compiled in with PPA_ROUND_ROBIN_EN.
module tb_pending_priority_arbiter;

  localparam int unsigned N = 8;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         clr;
  logic         ready;
  logic         valid;
  logic [2:0]   idx;
  logic [N-1:0] pending;

  int tests = 0;
  int fails = 0;
  logic [2:0] exp_q[$];

  pending_priority_arbiter #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .mask    (mask),
    .clr     (clr),
    .ready   (ready),
    .valid   (valid),
    .idx     (idx),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] e);
    exp_q.push_back(e);
  endtask

  // Handshake monitor: the offer seen with ready high is accepted at the
  // following rising edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      logic [2:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL accept_unexpected: observed idx %0d expected no accept", idx);
      end else begin
        e = exp_q.pop_front();
        assert (idx === e) else begin
          fails++;
          $error("FAIL accept_idx: observed %0d expected %0d", idx, e);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    req     = 8'hFF;
    mask    = '0;
    clr     = 1'b0;
    ready   = 1'b0;

    // Reset with all requests high
    step(2);
    chk("rst_valid", valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_idx", idx, 0);
    reset_n = 1'b1;
    step(1);
    chk("rel_pending", pending, 8'hFF);
    chk("rel_valid", valid, 0);
    req = '0;
    step(1);
    chk("first_valid", valid, 1);
    chk("first_idx", idx, 7);

    // Clear during OFFER
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_valid", valid, 0);
    chk("clr_pending", pending, 0);

    // Back-to-back drain of 1010_0100
    req = 8'hA4;
    step(1);
    req = '0;
    chk("drain_pending", pending, 8'hA4);
    push(7); push(5); push(2);
    ready = 1'b1;
    step(4);
    ready = 1'b0;
    chk("drain_valid", valid, 0);
    chk("drain_pending0", pending, 0);
    chk("drain_q", exp_q.size(), 0);

    // Stall stability: higher request and mask change do not move the offer
    req = 8'h08;
    step(1);
    req = '0;
    step(1);
    chk("stall_idx0", idx, 3);
    req = 8'h40;
    step(1);
    req = '0;
    mask = 8'h08;
    chk("stall_pending", pending, 8'h48);
    for (int i = 0; i < 4; i++) begin
      chk("stall_idx", idx, 3);
      chk("stall_valid", valid, 1);
      step(1);
    end
    push(3); push(6);
    ready = 1'b1;
    step(1);
    chk("stall_next", idx, 6);
    step(1);
    ready = 1'b0;
    mask  = '0;
    chk("stall_end_valid", valid, 0);
    chk("stall_end_pending", pending, 0);

    // Set-vs-clear collision on line 4
    req = 8'h10;
    step(2);
    chk("coll_idx", idx, 4);
    push(4); push(4);
    ready = 1'b1;
    step(1);
    req = '0;
    chk("coll_pending", pending, 8'h10);
    chk("coll_gap_valid", valid, 0);
    step(1);
    chk("coll_reoffer", idx, 4);
    chk("coll_reoffer_v", valid, 1);
    step(1);
    ready = 1'b0;
    chk("coll_end_pending", pending, 0);
    chk("coll_end_valid", valid, 0);

    // All pending lines masked
    mask = 8'h81;
    req  = 8'h81;
    step(1);
    req = '0;
    step(2);
    chk("mask_valid", valid, 0);
    chk("mask_pending", pending, 8'h81);
    mask = 8'h80;
    step(1);
    chk("unmask_valid", valid, 1);
    chk("unmask_idx", idx, 0);
    push(0);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("unmask_pending", pending, 8'h80);
    chk("unmask_end_valid", valid, 0);
    mask = '0;
    clr  = 1'b1;
    step(1);
    clr = 1'b0;
    chk("mask_clr", pending, 0);

    // clr and accept in the same cycle: clr wins, accept still counts
    req = 8'h06;
    step(1);
    req = '0;
    step(1);
    chk("ca_idx", idx, 2);
    push(2);
    ready = 1'b1;
    clr   = 1'b1;
    step(1);
    ready = 1'b0;
    clr   = 1'b0;
    chk("ca_valid", valid, 0);
    chk("ca_pending", pending, 0);
    chk("ca_idx_kept", idx, 2);

    // ready with nothing offered
    ready = 1'b1;
    step(2);
    ready = 1'b0;
    chk("idle_ready_valid", valid, 0);

    // Reset mid-offer
    req = 8'h20;
    step(2);
    req = '0;
    chk("midrst_pre", idx, 5);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("midrst_valid", valid, 0);
    chk("midrst_idx", idx, 0);
    chk("midrst_pending", pending, 0);

`ifdef PPA_ROUND_ROBIN_EN
    // Rotation with every line requesting
    req = 8'hFF;
    step(2);
    chk("rr_first", idx, 7);
    push(7); push(6); push(5); push(4); push(3); push(2); push(1); push(0); push(7);
    ready = 1'b1;
    step(9);
    ready = 1'b0;
    req   = '0;
    chk("rr_after_wrap", idx, 6);
    clr = 1'b1;
    step(1);
    clr = 1'b0;

    // Fairness: pointer now 6, so line 1 is offered first
    req = 8'h82;
    step(2);
    chk("fair_first", idx, 1);
    push(1); push(7); push(1); push(7);
    ready = 1'b1;
    step(4);
    ready = 1'b0;
    req   = '0;
    clr   = 1'b1;
    step(1);
    clr = 1'b0;
`endif

    step(1);
    chk("final_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
